// File: rtl/fetch_buffer.sv
// Instruction-fetch stage: req/ack fetch from instruction memory into a small prefetch FIFO, with PC redirect/flush.
// Optional FETCH_MISALIGN_EN adds a sticky fetch_misalign flag for misaligned redirect targets.
module fetch_buffer #(
  parameter int unsigned       ADDR_W   = 11,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
`ifdef FETCH_MISALIGN_EN
  ,output logic             fetch_misalign
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [ADDR_W-1:0] w_redir_pc, w_discard_tgt;
  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [31:0]       r_word_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]  r_count, w_count_post;
  logic              w_pop, w_push, w_flush;

  assign w_redir_pc    = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_discard_tgt = redirect_valid ? w_redir_pc : r_fetch_pc;
  assign instr_valid   = (r_count != '0);
  assign w_pop         = instr_valid && instr_ready;
  // Occupancy after this cycle's enqueue and pop; decides whether the next fetch has guaranteed space.
  assign w_count_post  = r_count + CNT_W'(1) - CNT_W'(w_pop);

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign instr    = r_word_mem[r_rd_ptr];
  assign instr_pc = r_pc_mem[r_rd_ptr];

  always_comb begin
    w_state_nxt    = r_state;
    w_mem_addr_nxt = r_mem_addr;
    w_fetch_pc_nxt = r_fetch_pc;
    w_push         = 1'b0;
    w_flush        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (redirect_valid) begin
          w_flush        = 1'b1;
          w_mem_addr_nxt = w_redir_pc;
          w_fetch_pc_nxt = w_redir_pc + ADDR_W'(4);
          w_state_nxt    = S_WAIT;
        end else if (r_count < CNT_W'(DEPTH)) begin
          w_mem_addr_nxt = r_fetch_pc;
          w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(4);
          w_state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack && redirect_valid) begin
          w_flush        = 1'b1;
          w_mem_addr_nxt = w_redir_pc;
          w_fetch_pc_nxt = w_redir_pc + ADDR_W'(4);
        end else if (mem_ack) begin
          w_push = 1'b1;
          if (w_count_post < CNT_W'(DEPTH)) begin
            w_mem_addr_nxt = r_fetch_pc;
            w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(4);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (redirect_valid) begin
          w_flush        = 1'b1;
          w_fetch_pc_nxt = w_redir_pc;
          w_state_nxt    = S_DISCARD;
        end
      end
      S_DISCARD: begin
        w_flush = redirect_valid;
        if (mem_ack) begin
          w_mem_addr_nxt = w_discard_tgt;
          w_fetch_pc_nxt = w_discard_tgt + ADDR_W'(4);
          w_state_nxt    = S_WAIT;
        end else if (redirect_valid) begin
          w_fetch_pc_nxt = w_redir_pc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_word_mem[i] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= (w_state_nxt != S_IDLE);
      r_mem_addr <= w_mem_addr_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      if (w_flush) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) begin
          r_pc_mem[r_wr_ptr]   <= r_mem_addr;
          r_word_mem[r_wr_ptr] <= mem_rdata;
          r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

`ifdef FETCH_MISALIGN_EN
  logic r_misalign;

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_misalign <= 1'b0;
    else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) r_misalign <= 1'b1;
  end

  assign fetch_misalign = r_misalign;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: expected instruction stream model, randomized ack latency, ready and redirects.
module tb_fetch_buffer;
  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 4;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready = 1'b0;
`ifdef FETCH_MISALIGN_EN
  logic          fetch_misalign;
`endif

  always #5 CLOCK_50 = ~CLOCK_50;

  fetch_buffer #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(11'h000)) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready)
`ifdef FETCH_MISALIGN_EN
    ,.fetch_misalign(fetch_misalign)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   word;
  } entry_t;

  int     errors = 0;
  int     checks = 0;
  entry_t exp_q[$];
  logic [AW-1:0] model_pc = '0;
  logic   exp_mis = 1'b0;
  int     mem_delay = 0;

  function automatic logic [31:0] rom(input logic [AW-1:0] a);
    return 32'h00500293 ^ 32'(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #2;
    end
  endtask

  task automatic redirect_once(input logic [AW-1:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for condition", name);
  endtask

  task automatic check_reset_state();
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", 32'(instr_pc), 32'h0);
`ifdef FETCH_MISALIGN_EN
    check("rst_misalign", 32'(fetch_misalign), 32'h0);
`endif
  endtask

  // Reference stream: what the core must see is the sequential PC run from the last redirect (or reset).
  initial begin
    entry_t e;
    forever begin
      @(posedge CLOCK_50);
      if (reset) begin
        exp_q.delete();
        model_pc = 11'h000;
        exp_mis  = 1'b0;
      end else if (redirect_valid) begin
        exp_q.delete();
        model_pc = {redirect_pc[AW-1:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) exp_mis = 1'b1;
      end
      while (exp_q.size() < 8) begin
        e.pc   = model_pc;
        e.word = rom(model_pc);
        exp_q.push_back(e);
        model_pc = model_pc + AW'(4);
      end
    end
  end

  // Instruction memory: one request at a time, ack after mem_delay cycles (random 0..3 when negative).
  bit            m_busy = 1'b0;
  bit            m_prev_req = 1'b0;
  int            m_cnt = 0;
  logic [AW-1:0] m_held = '0;
  initial begin
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (!mem_req) begin
        m_busy    = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end else begin
        if (m_busy && mem_ack && m_prev_req) m_busy = 1'b0;
        if (!m_busy) begin
          m_busy = 1'b1;
          m_held = mem_addr;
          m_cnt  = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
          check("addr_align", 32'(mem_addr[1:0]), 32'h0);
        end else begin
          check("addr_hold", 32'(mem_addr), 32'(m_held));
        end
        if (m_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = rom(mem_addr);
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
          m_cnt--;
        end
      end
      m_prev_req = mem_req;
    end
  end

  // Monitor: every pop is checked against the stream head; a stalled head must not change.
  initial begin
    logic          hold = 1'b0;
    logic          prev_redir = 1'b0;
    logic [31:0]   p_instr = '0;
    logic [AW-1:0] p_pc = '0;
    entry_t        e;
    forever begin
      @(negedge CLOCK_50);
      if (!reset) begin
        if (hold && !prev_redir) begin
          check("hold_instr", instr, p_instr);
          check("hold_pc", 32'(instr_pc), 32'(p_pc));
        end
        if (instr_valid && instr_ready) begin
          if (exp_q.size() == 0) begin
            timeout_fail("pop_no_expect");
          end else begin
            e = exp_q.pop_front();
            check("pop_pc", 32'(instr_pc), 32'(e.pc));
            check("pop_word", instr, e.word);
          end
        end
`ifdef FETCH_MISALIGN_EN
        check("misalign", 32'(fetch_misalign), 32'(exp_mis));
`endif
      end
      hold       = !reset && instr_valid && !instr_ready;
      prev_redir = redirect_valid;
      p_instr    = instr;
      p_pc       = instr_pc;
    end
  end

  initial begin
    int guard;
    mem_delay = 0;
    reset     = 1'b1;
    tick(3);
    check_reset_state();

    // Streaming with single-cycle ack and the core always ready
    reset       = 1'b0;
    instr_ready = 1'b1;
    tick(1);
    check("first_req", 32'(mem_req), 32'h1);
    check("first_addr", 32'(mem_addr), 32'h000);
    tick(1);
    check("first_valid", 32'(instr_valid), 32'h1);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("no_gap", 32'(instr_valid), 32'h1);
    end

    // Core stalls: FIFO fills and fetching stops
    instr_ready = 1'b0;
    tick(10);
    check("full_idle", 32'(mem_req), 32'h0);
    check("full_head", 32'(instr_pc), 32'(exp_q[0].pc));
    instr_ready = 1'b1;
    tick(8);

    // Redirect while a slow request is outstanding
    mem_delay = 3;
    guard = 0;
    while (!(mem_req && !mem_ack) && guard < 50) begin
      tick(1);
      guard++;
    end
    if (guard >= 50) timeout_fail("wait_pending");
    redirect_once(11'h020);
    check("flush_empty0", 32'(instr_valid), 32'h0);
    tick(1);
    check("flush_empty1", 32'(instr_valid), 32'h0);
    guard = 0;
    while (!instr_valid && guard < 50) begin
      tick(1);
      guard++;
    end
    if (guard >= 50) timeout_fail("wait_redirect_valid");
    check("redirect_first", 32'(instr_pc), 32'h020);
    tick(4);

    // Redirect coinciding with ack and pop
    mem_delay = 0;
    guard = 0;
    while (!(mem_req && mem_ack && instr_valid) && guard < 50) begin
      tick(1);
      guard++;
    end
    if (guard >= 50) timeout_fail("wait_ack_pop");
    redirect_once(11'h100);
    check("ackredir_empty", 32'(instr_valid), 32'h0);
    check("ackredir_req", 32'(mem_req), 32'h1);
    check("ackredir_addr", 32'(mem_addr), 32'h100);
    tick(6);

    // Address wrap at the top of the space
    redirect_once(11'h7F0);
    tick(14);

`ifdef FETCH_MISALIGN_EN
    redirect_once(11'h013);
    check("misalign_set", 32'(fetch_misalign), 32'h1);
    guard = 0;
    while (!instr_valid && guard < 50) begin
      tick(1);
      guard++;
    end
    if (guard >= 50) timeout_fail("wait_misalign_valid");
    check("misalign_first_pc", 32'(instr_pc), 32'h010);
    tick(4);
`endif

    // Randomized traffic
    mem_delay = -1;
    for (int i = 0; i < 800; i++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = AW'($urandom);
      tick(1);
    end
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    tick(10);

    reset = 1'b1;
    tick(2);
    check_reset_state();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
